id_ex_pipe: RTL and testbench

//  ID/EX pipeline register with load-use hazard detection, between decode and execute.

---
 rtl/wizard_pkg.sv | 42 ++++
 rtl/id_hazard_detect.sv | 27 ++
 rtl/id_ex_pipe.sv | 134 +++++++++++++
 tb/tb_id_ex_pipe.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/wizard_pkg.sv
// Shared widths, control-bundle bit positions and bubble constants for the ID/EX stage.
package wizard_pkg;

   localparam int XLEN       = 32;
   localparam int REG_AW     = 5;

   localparam int CTRL_EX_W  = 14;
   localparam int CTRL_MEM_W = 4;
   localparam int CTRL_WB_W  = 7;

   localparam int EX_ALUOP_HI  = 13;
   localparam int EX_ALUOP_LO  = 12;
   localparam int EX_ALUSRC_HI = 11;
   localparam int EX_ALUSRC_LO = 10;
   localparam int EX_FUNC3_HI  = 9;
   localparam int EX_FUNC3_LO  = 7;
   localparam int EX_FUNC7_HI  = 6;
   localparam int EX_FUNC7_LO  = 0;

   localparam int CTRL_JUMP     = 3;
   localparam int CTRL_BRANCH   = 2;
   localparam int CTRL_MEMREAD  = 1;
   localparam int CTRL_MEMWRITE = 0;

   localparam int WB_REGWRITE = 6;
   localparam int WB_MEMTOREG = 5;
   localparam int WB_RD_HI    = 4;
   localparam int WB_RD_LO    = 0;

   localparam logic [CTRL_EX_W-1:0]  BUBBLE_EX  = '0;
   localparam logic [CTRL_MEM_W-1:0] BUBBLE_MEM = '0;
   localparam logic [CTRL_WB_W-1:0]  BUBBLE_WB  = '0;

   function automatic logic [REG_AW-1:0] wb_rd(input logic [CTRL_WB_W-1:0] wb);
      return wb[WB_RD_HI:WB_RD_LO];
   endfunction

   function automatic logic mem_is_load(input logic [CTRL_MEM_W-1:0] mem);
      return mem[CTRL_MEMREAD];
   endfunction

endpackage

// File: rtl/id_hazard_detect.sv
// Load-use hazard detector: flags an ID instruction that reads the destination of a load in EX.
module id_hazard_detect
   import wizard_pkg::*;
(
   input  logic                  ex_valid_i,
   input  logic [CTRL_MEM_W-1:0] ex_ctrl_mem_i,
   input  logic [CTRL_WB_W-1:0]  ex_ctrl_wb_i,
   input  logic                  id_valid_i,
   input  logic [REG_AW-1:0]     id_rs1_i,
   input  logic [REG_AW-1:0]     id_rs2_i,
   output logic                  haz_o
);

   logic [REG_AW-1:0] ex_rd;
   logic              ex_load;
   logic              rd_nonzero;
   logic              src_match;

   assign ex_rd      = wb_rd(ex_ctrl_wb_i);
   assign ex_load    = ex_valid_i & mem_is_load(ex_ctrl_mem_i);
   // x0 is hardwired zero, so a load targeting it can never feed a dependent.
   assign rd_nonzero = (ex_rd != '0);
   assign src_match  = (ex_rd == id_rs1_i) | (ex_rd == id_rs2_i);

   assign haz_o = ex_load & rd_nonzero & id_valid_i & src_match;

endmodule

// File: rtl/id_ex_pipe.sv
// ID/EX pipeline register with load-use bubble insertion, branch flush and downstream hold.
module id_ex_pipe
   import wizard_pkg::*;
#(
   parameter int XLEN   = 32,
   parameter int REG_AW = 5
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic                  i_hold,
   input  logic                  i_flush,
   input  logic                  i_valid,
   input  logic [XLEN-1:0]       i_pc,
   input  logic [XLEN-1:0]       i_rdData1,
   input  logic [XLEN-1:0]       i_rdData2,
   input  logic [XLEN-1:0]       i_imm,
   input  logic [REG_AW-1:0]     i_rdReg1,
   input  logic [REG_AW-1:0]     i_rdReg2,
   input  logic [CTRL_EX_W-1:0]  i_ctrlEX,
   input  logic [CTRL_MEM_W-1:0] i_ctrlMEM,
   input  logic [CTRL_WB_W-1:0]  i_ctrlWB,
   output logic                  o_stall,
   output logic                  o_valid,
   output logic [XLEN-1:0]       o_pc,
   output logic [XLEN-1:0]       o_rdData1,
   output logic [XLEN-1:0]       o_rdData2,
   output logic [XLEN-1:0]       o_imm,
   output logic [REG_AW-1:0]     o_rdReg1,
   output logic [REG_AW-1:0]     o_rdReg2,
   output logic [CTRL_EX_W-1:0]  o_ctrlEX,
   output logic [CTRL_MEM_W-1:0] o_ctrlMEM,
   output logic [CTRL_WB_W-1:0]  o_ctrlWB
);

   logic                  valid_q,   valid_d;
   logic [XLEN-1:0]       pc_q,      pc_d;
   logic [XLEN-1:0]       data1_q,   data1_d;
   logic [XLEN-1:0]       data2_q,   data2_d;
   logic [XLEN-1:0]       imm_q,     imm_d;
   logic [REG_AW-1:0]     rs1_q,     rs1_d;
   logic [REG_AW-1:0]     rs2_q,     rs2_d;
   logic [CTRL_EX_W-1:0]  ctrl_ex_q, ctrl_ex_d;
   logic [CTRL_MEM_W-1:0] ctrl_mem_q, ctrl_mem_d;
   logic [CTRL_WB_W-1:0]  ctrl_wb_q, ctrl_wb_d;
   logic                  haz;

   id_hazard_detect u_haz (
      .ex_valid_i    (valid_q),
      .ex_ctrl_mem_i (ctrl_mem_q),
      .ex_ctrl_wb_i  (ctrl_wb_q),
      .id_valid_i    (i_valid),
      .id_rs1_i      (i_rdReg1),
      .id_rs2_i      (i_rdReg2),
      .haz_o         (haz)
   );

   // A flushed ID instruction is wrong-path, and a held pipe cannot advance,
   // so neither may stall the front end.
   assign o_stall = haz & ~i_flush & ~i_hold;

   always_comb begin
      valid_d    = valid_q;
      pc_d       = pc_q;
      data1_d    = data1_q;
      data2_d    = data2_q;
      imm_d      = imm_q;
      rs1_d      = rs1_q;
      rs2_d      = rs2_q;
      ctrl_ex_d  = ctrl_ex_q;
      ctrl_mem_d = ctrl_mem_q;
      ctrl_wb_d  = ctrl_wb_q;
      if (i_flush || (!i_hold && haz)) begin
         valid_d    = 1'b0;
         pc_d       = '0;
         data1_d    = '0;
         data2_d    = '0;
         imm_d      = '0;
         rs1_d      = '0;
         rs2_d      = '0;
         ctrl_ex_d  = BUBBLE_EX;
         ctrl_mem_d = BUBBLE_MEM;
         ctrl_wb_d  = BUBBLE_WB;
      end else if (!i_hold) begin
         valid_d    = i_valid;
         pc_d       = i_pc;
         data1_d    = i_rdData1;
         data2_d    = i_rdData2;
         imm_d      = i_imm;
         rs1_d      = i_rdReg1;
         rs2_d      = i_rdReg2;
         ctrl_ex_d  = i_ctrlEX;
         ctrl_mem_d = i_ctrlMEM;
         ctrl_wb_d  = i_ctrlWB;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         valid_q    <= 1'b0;
         pc_q       <= '0;
         data1_q    <= '0;
         data2_q    <= '0;
         imm_q      <= '0;
         rs1_q      <= '0;
         rs2_q      <= '0;
         ctrl_ex_q  <= BUBBLE_EX;
         ctrl_mem_q <= BUBBLE_MEM;
         ctrl_wb_q  <= BUBBLE_WB;
      end else begin
         valid_q    <= valid_d;
         pc_q       <= pc_d;
         data1_q    <= data1_d;
         data2_q    <= data2_d;
         imm_q      <= imm_d;
         rs1_q      <= rs1_d;
         rs2_q      <= rs2_d;
         ctrl_ex_q  <= ctrl_ex_d;
         ctrl_mem_q <= ctrl_mem_d;
         ctrl_wb_q  <= ctrl_wb_d;
      end
   end

   assign o_valid   = valid_q;
   assign o_pc      = pc_q;
   assign o_rdData1 = data1_q;
   assign o_rdData2 = data2_q;
   assign o_imm     = imm_q;
   assign o_rdReg1  = rs1_q;
   assign o_rdReg2  = rs2_q;
   assign o_ctrlEX  = ctrl_ex_q;
   assign o_ctrlMEM = ctrl_mem_q;
   assign o_ctrlWB  = ctrl_wb_q;

endmodule

// File: tb/tb_id_ex_pipe.sv
// Directed bench for id_ex_pipe: capture, load-use bubble, x0, flush, hold and async reset.
module tb_id_ex_pipe;

   logic        i_clk = 1'b0;
   logic        i_rst_n;
   logic        i_hold, i_flush, i_valid;
   logic [31:0] i_pc, i_rdData1, i_rdData2, i_imm;
   logic [4:0]  i_rdReg1, i_rdReg2;
   logic [13:0] i_ctrlEX;
   logic [3:0]  i_ctrlMEM;
   logic [6:0]  i_ctrlWB;
   logic        o_stall, o_valid;
   logic [31:0] o_pc, o_rdData1, o_rdData2, o_imm;
   logic [4:0]  o_rdReg1, o_rdReg2;
   logic [13:0] o_ctrlEX;
   logic [3:0]  o_ctrlMEM;
   logic [6:0]  o_ctrlWB;

   int n_checks = 0;
   int n_passed = 0;

   id_ex_pipe #(.XLEN(32), .REG_AW(5)) dut (
      .i_clk(i_clk), .i_rst_n(i_rst_n), .i_hold(i_hold), .i_flush(i_flush),
      .i_valid(i_valid), .i_pc(i_pc), .i_rdData1(i_rdData1), .i_rdData2(i_rdData2),
      .i_imm(i_imm), .i_rdReg1(i_rdReg1), .i_rdReg2(i_rdReg2), .i_ctrlEX(i_ctrlEX),
      .i_ctrlMEM(i_ctrlMEM), .i_ctrlWB(i_ctrlWB), .o_stall(o_stall), .o_valid(o_valid),
      .o_pc(o_pc), .o_rdData1(o_rdData1), .o_rdData2(o_rdData2), .o_imm(o_imm),
      .o_rdReg1(o_rdReg1), .o_rdReg2(o_rdReg2), .o_ctrlEX(o_ctrlEX),
      .o_ctrlMEM(o_ctrlMEM), .o_ctrlWB(o_ctrlWB)
   );

   always #5 i_clk = ~i_clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_passed++;
      else $display("FAIL %s: got %h expected %h", tag, obs, exp);
   endtask

   task automatic step();
      @(posedge i_clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [31:0] pc, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [13:0] ex,
                        input logic [3:0] mem, input logic [6:0] wb);
      i_valid   = v;
      i_pc      = pc;
      i_rdReg1  = rs1;
      i_rdReg2  = rs2;
      i_ctrlEX  = ex;
      i_ctrlMEM = mem;
      i_ctrlWB  = wb;
      i_rdData1 = pc ^ 32'h1111_0000;
      i_rdData2 = pc ^ 32'h2222_0000;
      i_imm     = pc + 32'd7;
   endtask

   initial begin
      i_rst_n = 1'b0;
      i_hold  = 1'b0;
      i_flush = 1'b0;
      drive(1'b0, 32'h0, 5'd0, 5'd0, 14'h0, 4'h0, 7'h0);
      repeat (2) step();
      check("rst_valid", {31'b0, o_valid}, 32'h0);
      check("rst_stall", {31'b0, o_stall}, 32'h0);
      i_rst_n = 1'b1;
      step();
      check("idle_valid", {31'b0, o_valid}, 32'h0);
      check("idle_ctrlEX", {18'b0, o_ctrlEX}, 32'h0);
      check("idle_pc", o_pc, 32'h0);
      check("idle_stall", {31'b0, o_stall}, 32'h0);

      // R-type, rd=5
      drive(1'b1, 32'h100, 5'd1, 5'd2, 14'h2000, 4'h0, 7'h45);
      step();
      check("r_valid", {31'b0, o_valid}, 32'h1);
      check("r_ctrlEX", {18'b0, o_ctrlEX}, 32'h2000);
      check("r_ctrlWB", {25'b0, o_ctrlWB}, 32'h45);
      check("r_pc", o_pc, 32'h100);
      check("r_data1", o_rdData1, 32'h1111_0100);
      check("r_data2", o_rdData2, 32'h2222_0100);
      check("r_imm", o_imm, 32'h107);
      check("r_rs1", {27'b0, o_rdReg1}, 32'h1);
      check("r_rs2", {27'b0, o_rdReg2}, 32'h2);

      // Load rd=3 followed by add reading x3
      drive(1'b1, 32'h104, 5'd4, 5'd0, 14'h0400, 4'h2, 7'h63);
      #1 check("ld_nostall", {31'b0, o_stall}, 32'h0);
      step();
      drive(1'b1, 32'h108, 5'd3, 5'd0, 14'h2000, 4'h0, 7'h45);
      #1 check("lu_stall", {31'b0, o_stall}, 32'h1);
      step();
      check("lu_bub_valid", {31'b0, o_valid}, 32'h0);
      check("lu_bub_mem", {28'b0, o_ctrlMEM}, 32'h0);
      check("lu_bub_wb", {25'b0, o_ctrlWB}, 32'h0);
      check("lu_bub_pc", o_pc, 32'h0);
      check("lu_after_stall", {31'b0, o_stall}, 32'h0);
      step();
      check("lu_add_valid", {31'b0, o_valid}, 32'h1);
      check("lu_add_pc", o_pc, 32'h108);
      check("lu_add_wb", {25'b0, o_ctrlWB}, 32'h45);

      // Load to x0 never stalls
      drive(1'b1, 32'h10c, 5'd0, 5'd0, 14'h0400, 4'h2, 7'h60);
      step();
      drive(1'b1, 32'h110, 5'd0, 5'd0, 14'h2000, 4'h0, 7'h45);
      #1 check("x0_stall", {31'b0, o_stall}, 32'h0);
      step();
      check("x0_valid", {31'b0, o_valid}, 32'h1);
      check("x0_pc", o_pc, 32'h110);

      // Hazard with flush: flush wins
      drive(1'b1, 32'h114, 5'd0, 5'd0, 14'h0400, 4'h2, 7'h63);
      step();
      drive(1'b1, 32'h118, 5'd0, 5'd3, 14'h2000, 4'h0, 7'h45);
      i_flush = 1'b1;
      #1 check("fl_stall", {31'b0, o_stall}, 32'h0);
      step();
      i_flush = 1'b0;
      check("fl_valid", {31'b0, o_valid}, 32'h0);
      check("fl_mem", {28'b0, o_ctrlMEM}, 32'h0);
      check("fl_pc", o_pc, 32'h0);

      // Hazard with hold: freeze, then stall once hold drops
      drive(1'b1, 32'h11c, 5'd0, 5'd0, 14'h0400, 4'h2, 7'h63);
      step();
      drive(1'b1, 32'h120, 5'd3, 5'd0, 14'h2000, 4'h0, 7'h45);
      i_hold = 1'b1;
      for (int k = 0; k < 3; k++) begin
         #1 check("hold_stall", {31'b0, o_stall}, 32'h0);
         step();
         check("hold_pc", o_pc, 32'h11c);
         check("hold_mem", {28'b0, o_ctrlMEM}, 32'h2);
         check("hold_wb", {25'b0, o_ctrlWB}, 32'h63);
      end
      i_hold = 1'b0;
      #1 check("unhold_stall", {31'b0, o_stall}, 32'h1);

      // Async reset mid-stall
      i_rst_n = 1'b0;
      #1;
      check("arst_valid", {31'b0, o_valid}, 32'h0);
      check("arst_pc", o_pc, 32'h0);
      check("arst_mem", {28'b0, o_ctrlMEM}, 32'h0);
      check("arst_wb", {25'b0, o_ctrlWB}, 32'h0);
      check("arst_stall", {31'b0, o_stall}, 32'h0);
      step();
      i_rst_n = 1'b1;
      step();
      check("post_rst_pc", o_pc, 32'h120);

      $display("%0d/%0d checks passed", n_passed, n_checks);
      $finish;
   end

endmodule
